// File: rtl/muldiv_unit_pkg.sv
// Shared op and FSM encodings for the HI/LO multiply/divide unit.
// Used by the ALU, the decoder and muldiv_unit.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Unsigned restoring divider: one quotient bit per step, WIDTH steps after load.
// A zero divisor naturally yields an all-ones quotient and remainder = dividend.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   trial;

  always_comb begin
    partial = {rem_q, quo_q[WIDTH-1]};
    trial   = partial - {1'b0, dvs_q};
  end

  // trial MSB set means the subtraction borrowed: restore and shift in a 0
  always_ff @(posedge clk) begin
    if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      if (trial[WIDTH]) begin
        rem_q <= partial[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end else begin
        rem_q <= trial[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit with MTHI/MTLO and cancel support.
// Define MULDIV_DIV_EN to include the iterative divider; otherwise DIV/DIVU complete as no-ops.
import muldiv_unit_pkg::*;

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  state_e             state;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               accept;
  logic               signed_op;
  logic [2*WIDTH-1:0] product;

  assign accept = (state == ST_IDLE) && start_i && !cancel_i;

  // Sign- or zero-extend both operands so one 2*WIDTH multiply serves MULT and MULTU
  always_comb begin
    signed_op = op_is_signed(op_q);
    product   = {{WIDTH{signed_op & a_q[WIDTH-1]}}, a_q} *
                {{WIDTH{signed_op & b_q[WIDTH-1]}}, b_q};
  end

`ifdef MULDIV_DIV_EN
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt;
  logic             in_signed;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] lo_fix;
  logic [WIDTH-1:0] hi_fix;

  // Divider works on magnitudes; FIX restores signs (remainder follows the dividend)
  always_comb begin
    in_signed = op_is_signed(op_i);
    a_mag     = (in_signed && a_i[WIDTH-1]) ? -a_i : a_i;
    b_mag     = (in_signed && b_i[WIDTH-1]) ? -b_i : b_i;
    if (b_q == '0)
      lo_fix = '1;
    else if (signed_op && (a_q[WIDTH-1] ^ b_q[WIDTH-1]))
      lo_fix = -quo;
    else
      lo_fix = quo;
    hi_fix = (signed_op && a_q[WIDTH-1]) ? -rem : rem;
  end

  div_iter #(.WIDTH(WIDTH)) u_div_iter (
    .clk       (clk),
    .load      (accept && ((op_i == OP_DIV) || (op_i == OP_DIVU))),
    .step      (state == ST_DIV),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quo),
    .remainder (rem)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
    end else begin
      done_o <= 1'b0;
      if ((state != ST_IDLE) && cancel_i) begin
        state  <= ST_IDLE;
        busy_o <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              op_q <= op_i;
              a_q  <= a_i;
              b_q  <= b_i;
              case (op_i)
                OP_MTHI: begin
                  hi_o   <= a_i;
                  done_o <= 1'b1;
                end
                OP_MTLO: begin
                  lo_o   <= a_i;
                  done_o <= 1'b1;
                end
                OP_MULT, OP_MULTU: begin
                  state  <= ST_MUL;
                  busy_o <= 1'b1;
                end
                OP_DIV, OP_DIVU: begin
`ifdef MULDIV_DIV_EN
                  state  <= ST_DIV;
                  busy_o <= 1'b1;
                  cnt    <= '0;
`else
                  done_o <= 1'b1;
`endif
                end
                default: ;
              endcase
            end
          end
          ST_MUL: begin
            {hi_o, lo_o} <= product;
            done_o       <= 1'b1;
            state        <= ST_IDLE;
            busy_o       <= 1'b0;
          end
`ifdef MULDIV_DIV_EN
          ST_DIV: begin
            if (cnt == CW'(WIDTH - 1))
              state <= ST_FIX;
            else
              cnt <= cnt + CW'(1);
          end
          ST_FIX: begin
            hi_o   <= hi_fix;
            lo_o   <= lo_fix;
            done_o <= 1'b1;
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
`endif
          default: begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench: drives a 32-bit and a 16-bit muldiv_unit in parallel
// against an arithmetic reference model; follows MULDIV_DIV_EN for DIV behaviour.
module tb_muldiv_unit;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy32, done32, busy16, done16;
  logic [31:0] hi32, lo32;
  logic [15:0] hi16, lo16;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_hi32 = '0, m_lo32 = '0, m_hi16 = '0, m_lo16 = '0;
  int lat32, lat16, cnt32, cnt16, bad32, bad16;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .cancel_i(cancel), .busy_o(busy32), .done_o(done32), .hi_o(hi32), .lo_o(lo32)
  );

  muldiv_unit #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .a_i(a[15:0]), .b_i(b[15:0]),
    .cancel_i(cancel), .busy_o(busy16), .done_o(done16), .hi_o(hi16), .lo_o(lo16)
  );

  // Architectural result of one op on a w-bit unit, returned as {hi, lo}
  function automatic logic [63:0] model_op(input int w, input logic [2:0] o,
                                           input logic [31:0] ai, input logic [31:0] bi,
                                           input logic [31:0] h, input logic [31:0] l);
    longint unsigned mask, ua, ub, pu;
    longint          sa, sb, p;
    logic [31:0]     nh, nl;
    mask = (64'd1 << w) - 64'd1;
    ua = ai & mask;
    ub = bi & mask;
    sa = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    sb = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    nh = h;
    nl = l;
    case (o)
      3'd0: begin p = sa * sb; nl = 32'(p & mask); nh = 32'((p >>> w) & mask); end
      3'd1: begin pu = ua * ub; nl = 32'(pu & mask); nh = 32'((pu >> w) & mask); end
      3'd2: if (DIV_EN) begin
        if (ub == 0) begin nl = 32'(mask); nh = 32'(ua); end
        else begin nl = 32'((sa / sb) & mask); nh = 32'((sa % sb) & mask); end
      end
      3'd3: if (DIV_EN) begin
        if (ub == 0) begin nl = 32'(mask); nh = 32'(ua); end
        else begin nl = 32'(ua / ub); nh = 32'(ua % ub); end
      end
      3'd4: nh = 32'(ua);
      3'd5: nl = 32'(ua);
      default: ;
    endcase
    return {nh, nl};
  endfunction

  // Cycle (counting the accept cycle as 0) in which done is expected; -1 = never
  function automatic int exp_lat(input int w, input logic [2:0] o);
    case (o)
      3'd0, 3'd1: return 2;
      3'd2, 3'd3: return DIV_EN ? w + 2 : 1;
      3'd4, 3'd5: return 1;
      default:    return -1;
    endcase
  endfunction

  // One-cycle start pulse, then 40 cycles of observation with scrambled inputs
  task automatic issue(input logic [2:0] o, input logic [31:0] ai, input logic [31:0] bi);
    logic [31:0] ph32, pl32;
    logic [15:0] ph16, pl16;
    @(negedge clk);
    start = 1'b1; op = o; a = ai; b = bi;
    ph32 = hi32; pl32 = lo32; ph16 = hi16; pl16 = lo16;
    lat32 = -1; lat16 = -1; cnt32 = 0; cnt16 = 0; bad32 = 0; bad16 = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done32) begin cnt32++; if (lat32 < 0) lat32 = c; end
      else if (hi32 !== ph32 || lo32 !== pl32) bad32++;
      if (done16) begin cnt16++; if (lat16 < 0) lat16 = c; end
      else if (hi16 !== ph16 || lo16 !== pl16) bad16++;
      ph32 = hi32; pl32 = lo32; ph16 = hi16; pl16 = lo16;
      if (c == 1) begin start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cancel = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (hi32 !== 32'h0) begin n_fail++; $display("[TB] FAIL reset hi32: got %h want 0", hi32); end
    n_tests++; if (lo32 !== 32'h0) begin n_fail++; $display("[TB] FAIL reset lo32: got %h want 0", lo32); end
    n_tests++; if (hi16 !== 16'h0 || lo16 !== 16'h0) begin n_fail++; $display("[TB] FAIL reset hilo16: got %h/%h want 0/0", hi16, lo16); end
    n_tests++; if ({busy32, done32, busy16, done16} !== 4'b0) begin n_fail++; $display("[TB] FAIL reset flags: got %b want 0000", {busy32, done32, busy16, done16}); end
    rst = 1'b0;
  endtask

  task automatic test_mult_vectors();
    issue(3'd0, 32'hFFFFFFFE, 32'd3);
    {m_hi32, m_lo32} = model_op(32, 3'd0, 32'hFFFFFFFE, 32'd3, m_hi32, m_lo32);
    {m_hi16, m_lo16} = model_op(16, 3'd0, 32'hFFFFFFFE, 32'd3, m_hi16, m_lo16);
    n_tests++; if (lat32 != 2) begin n_fail++; $display("[TB] FAIL mult lat: got %0d want 2", lat32); end
    n_tests++; if ({hi32, lo32} !== 64'hFFFFFFFF_FFFFFFFA) begin n_fail++; $display("[TB] FAIL mult hilo: got %h%h want FFFFFFFFFFFFFFFA", hi32, lo32); end
    issue(3'd1, 32'hFFFFFFFE, 32'd3);
    {m_hi32, m_lo32} = model_op(32, 3'd1, 32'hFFFFFFFE, 32'd3, m_hi32, m_lo32);
    {m_hi16, m_lo16} = model_op(16, 3'd1, 32'hFFFFFFFE, 32'd3, m_hi16, m_lo16);
    n_tests++; if ({hi32, lo32} !== 64'h00000002_FFFFFFFA) begin n_fail++; $display("[TB] FAIL multu hilo: got %h%h want 00000002FFFFFFFA", hi32, lo32); end
    n_tests++; if ({hi16, lo16} !== 32'h0002_FFFA) begin n_fail++; $display("[TB] FAIL multu16 hilo: got %h%h want 0002FFFA", hi16, lo16); end
  endtask

  task automatic test_directed();
    logic [2:0]  t_op [13] = '{3'd2, 3'd3, 3'd3, 3'd2, 3'd2, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd3};
    logic [31:0] t_a  [13] = '{32'hFFFFFFF9, 32'd100, 32'h1234, 32'h80000000, 32'h00008000, 32'hFFFFFFF9,
                               32'hDEADBEEF, 32'h12345678, 32'hAAAA5555, 32'h5555AAAA, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] t_b  [13] = '{32'd2, 32'd7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,
                               32'd0, 32'd0, 32'd1, 32'd1, 32'h80000000, 32'hFFFFFFFF, 32'd1};
    for (int i = 0; i < 13; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      {m_hi32, m_lo32} = model_op(32, t_op[i], t_a[i], t_b[i], m_hi32, m_lo32);
      {m_hi16, m_lo16} = model_op(16, t_op[i], t_a[i], t_b[i], m_hi16, m_lo16);
      n_tests++; if (lat32 != exp_lat(32, t_op[i])) begin n_fail++; $display("[TB] FAIL dir%0d lat32: got %0d want %0d", i, lat32, exp_lat(32, t_op[i])); end
      n_tests++; if (lat16 != exp_lat(16, t_op[i])) begin n_fail++; $display("[TB] FAIL dir%0d lat16: got %0d want %0d", i, lat16, exp_lat(16, t_op[i])); end
      n_tests++; if (cnt32 != cnt16 || cnt32 != (exp_lat(32, t_op[i]) > 0 ? 1 : 0)) begin n_fail++; $display("[TB] FAIL dir%0d done count: got %0d/%0d", i, cnt32, cnt16); end
      n_tests++; if (hi32 !== m_hi32 || lo32 !== m_lo32) begin n_fail++; $display("[TB] FAIL dir%0d hilo32: got %h/%h want %h/%h", i, hi32, lo32, m_hi32, m_lo32); end
      n_tests++; if (hi16 !== m_hi16[15:0] || lo16 !== m_lo16[15:0]) begin n_fail++; $display("[TB] FAIL dir%0d hilo16: got %h/%h want %h/%h", i, hi16, lo16, m_hi16[15:0], m_lo16[15:0]); end
      n_tests++; if (bad32 != 0 || bad16 != 0) begin n_fail++; $display("[TB] FAIL dir%0d early hilo change: got %0d/%0d want 0/0", i, bad32, bad16); end
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] ra, rb;
    for (int i = 0; i < 30; i++) begin
      o  = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      issue(o, ra, rb);
      {m_hi32, m_lo32} = model_op(32, o, ra, rb, m_hi32, m_lo32);
      {m_hi16, m_lo16} = model_op(16, o, ra, rb, m_hi16, m_lo16);
      n_tests++; if (lat32 != exp_lat(32, o) || lat16 != exp_lat(16, o)) begin n_fail++; $display("[TB] FAIL rnd%0d op%0d lat: got %0d/%0d want %0d/%0d", i, o, lat32, lat16, exp_lat(32, o), exp_lat(16, o)); end
      n_tests++; if (hi32 !== m_hi32 || lo32 !== m_lo32) begin n_fail++; $display("[TB] FAIL rnd%0d op%0d hilo32: got %h/%h want %h/%h (a=%h b=%h)", i, o, hi32, lo32, m_hi32, m_lo32, ra, rb); end
      n_tests++; if (hi16 !== m_hi16[15:0] || lo16 !== m_lo16[15:0]) begin n_fail++; $display("[TB] FAIL rnd%0d op%0d hilo16: got %h/%h want %h/%h", i, o, hi16, lo16, m_hi16[15:0], m_lo16[15:0]); end
      n_tests++; if (bad32 != 0 || bad16 != 0 || cnt32 > 1 || cnt16 > 1) begin n_fail++; $display("[TB] FAIL rnd%0d commit: got bad %0d/%0d dones %0d/%0d", i, bad32, bad16, cnt32, cnt16); end
    end
  endtask

  task automatic test_cancel();
    int dn;
    issue(3'd4, 32'hDEADBEEF, 32'd0);
    {m_hi32, m_lo32} = model_op(32, 3'd4, 32'hDEADBEEF, 32'd0, m_hi32, m_lo32);
    {m_hi16, m_lo16} = model_op(16, 3'd4, 32'hDEADBEEF, 32'd0, m_hi16, m_lo16);
    @(negedge clk); start = 1'b1; op = 3'd0; a = $urandom; b = $urandom;
    @(negedge clk); start = 1'b0; cancel = 1'b1;
    dn = int'(done32) + int'(done16);
    n_tests++; if (busy32 !== 1'b1) begin n_fail++; $display("[TB] FAIL cancel busy before: got %b want 1", busy32); end
    @(negedge clk); cancel = 1'b0;
    dn += int'(done32) + int'(done16);
    n_tests++; if (busy32 !== 1'b0 || busy16 !== 1'b0) begin n_fail++; $display("[TB] FAIL cancel busy after: got %b/%b want 0/0", busy32, busy16); end
    n_tests++; if (hi32 !== 32'hDEADBEEF || hi16 !== 16'hBEEF) begin n_fail++; $display("[TB] FAIL cancel hi: got %h/%h want DEADBEEF/BEEF", hi32, hi16); end
    repeat (4) begin @(negedge clk); dn += int'(done32) + int'(done16); end
    n_tests++; if (dn != 0 || lo32 !== m_lo32 || lo16 !== m_lo16[15:0]) begin n_fail++; $display("[TB] FAIL cancel mult: got dones %0d lo %h want 0 %h", dn, lo32, m_lo32); end
`ifdef MULDIV_DIV_EN
    @(negedge clk); start = 1'b1; op = 3'd3; a = $urandom; b = 32'd3;
    @(negedge clk); start = 1'b0;
    dn = 0;
    repeat (4) begin @(negedge clk); dn += int'(done32) + int'(done16); end
    cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
    n_tests++; if (busy32 !== 1'b0 || busy16 !== 1'b0) begin n_fail++; $display("[TB] FAIL cancel div busy: got %b/%b want 0/0", busy32, busy16); end
    repeat (40) begin @(negedge clk); dn += int'(done32) + int'(done16); end
    n_tests++; if (dn != 0 || hi32 !== m_hi32 || lo32 !== m_lo32 || hi16 !== m_hi16[15:0]) begin n_fail++; $display("[TB] FAIL cancel div: got dones %0d hilo %h/%h want 0 %h/%h", dn, hi32, lo32, m_hi32, m_lo32); end
`endif
    // cancel alongside start in IDLE must drop the request entirely
    @(negedge clk); start = 1'b1; cancel = 1'b1; op = 3'd4; a = 32'h13579BDF;
    @(negedge clk); start = 1'b0; cancel = 1'b0;
    n_tests++; if (done32 !== 1'b0 || done16 !== 1'b0 || busy32 !== 1'b0) begin n_fail++; $display("[TB] FAIL cancel+start flags: got %b%b%b want 000", done32, done16, busy32); end
    n_tests++; if (hi32 !== m_hi32 || hi16 !== m_hi16[15:0]) begin n_fail++; $display("[TB] FAIL cancel+start hi: got %h/%h want %h/%h", hi32, hi16, m_hi32, m_hi16[15:0]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x, y;
    int d32, d16;
    x = $urandom; y = $urandom; d32 = 0; d16 = 0;
    @(negedge clk); start = 1'b1; op = 3'd0; a = x; b = y;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      d32 += int'(done32); d16 += int'(done16);
      if (c == 1) begin a = $urandom; b = $urandom; end
      else start = 1'b0;
    end
    {m_hi32, m_lo32} = model_op(32, 3'd0, x, y, m_hi32, m_lo32);
    {m_hi16, m_lo16} = model_op(16, 3'd0, x, y, m_hi16, m_lo16);
    n_tests++; if (d32 != 1 || d16 != 1) begin n_fail++; $display("[TB] FAIL held mult dones: got %0d/%0d want 1/1", d32, d16); end
    n_tests++; if (hi32 !== m_hi32 || lo32 !== m_lo32 || hi16 !== m_hi16[15:0] || lo16 !== m_lo16[15:0]) begin n_fail++; $display("[TB] FAIL held mult hilo: got %h/%h want %h/%h", hi32, lo32, m_hi32, m_lo32); end
`ifdef MULDIV_DIV_EN
    x = $urandom; y = 32'($urandom_range(1, 5000)); d32 = 0; d16 = 0;
    @(negedge clk); start = 1'b1; op = 3'd3; a = x; b = y;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      d32 += int'(done32); d16 += int'(done16);
      if (c <= 10) begin a = $urandom; b = $urandom; end
      else start = 1'b0;
    end
    {m_hi32, m_lo32} = model_op(32, 3'd3, x, y, m_hi32, m_lo32);
    {m_hi16, m_lo16} = model_op(16, 3'd3, x, y, m_hi16, m_lo16);
    n_tests++; if (d32 != 1 || d16 != 1) begin n_fail++; $display("[TB] FAIL held divu dones: got %0d/%0d want 1/1", d32, d16); end
    n_tests++; if (hi32 !== m_hi32 || lo32 !== m_lo32 || hi16 !== m_hi16[15:0] || lo16 !== m_lo16[15:0]) begin n_fail++; $display("[TB] FAIL held divu hilo: got %h/%h want %h/%h", hi32, lo32, m_hi32, m_lo32); end
`endif
  endtask

  task automatic test_reset_mid();
    int dn;
    issue(3'd4, 32'h55AA55AA, 32'd0);
    issue(3'd5, 32'h0F0F0F0F, 32'd0);
    @(negedge clk); start = 1'b1; op = DIV_EN ? 3'd3 : 3'd0; a = $urandom; b = 32'd7;
    @(negedge clk); start = 1'b0;
    if (DIV_EN) repeat (3) @(negedge clk);
    // reset must win over a simultaneous cancel and MTHI request
    rst = 1'b1; start = 1'b1; cancel = 1'b1; op = 3'd4; a = 32'hFFFFFFFF;
    @(negedge clk); rst = 1'b0; start = 1'b0; cancel = 1'b0;
    m_hi32 = '0; m_lo32 = '0; m_hi16 = '0; m_lo16 = '0;
    n_tests++; if (hi32 !== 32'h0 || lo32 !== 32'h0 || hi16 !== 16'h0 || lo16 !== 16'h0) begin n_fail++; $display("[TB] FAIL reset mid hilo: got %h/%h %h/%h want 0", hi32, lo32, hi16, lo16); end
    n_tests++; if ({busy32, busy16, done32, done16} !== 4'b0) begin n_fail++; $display("[TB] FAIL reset mid flags: got %b want 0000", {busy32, busy16, done32, done16}); end
    dn = 0;
    repeat (40) begin @(negedge clk); dn += int'(done32) + int'(done16); end
    n_tests++; if (dn != 0 || hi32 !== 32'h0 || lo32 !== 32'h0) begin n_fail++; $display("[TB] FAIL reset mid after: got dones %0d hilo %h/%h want 0 0/0", dn, hi32, lo32); end
  endtask

  initial begin
    test_reset();
    test_mult_vectors();
    test_directed();
    test_cancel();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
